// File: rtl/sec_switch_matrix_cfg.sv
// sec_switch_matrix_cfg: per-lane 4:1 routing matrix for ctrl/sec tiles
// with a word-serial loader, shadow register and atomic commit.
module sec_switch_matrix_cfg #(
  parameter int NUM_CH     = 8,
  parameter int CFG_IN_W   = 8,
  parameter int OUT_REG_EN = 1,
  localparam int NUM_OUT   = 3 * NUM_CH,
  localparam int CFG_W     = 3 * NUM_OUT
) (
  input  logic                UserCLK,
  input  logic                rst,
  input  logic [NUM_CH-1:0]   from_E,
  input  logic [NUM_CH-1:0]   from_W,
  input  logic [NUM_CH-1:0]   from_N,
  input  logic [NUM_CH-1:0]   from_S,
  output logic [NUM_CH-1:0]   to_W,
  output logic [NUM_CH-1:0]   to_N,
  output logic [NUM_CH-1:0]   to_S,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CFG_IN_W-1:0] cfg_data,
  input  logic                cfg_last,
  output logic                cfg_done,
  output logic                cfg_err,
  output logic [CFG_W-1:0]    cfg_active
);

  localparam int WORDS = (CFG_W + CFG_IN_W - 1) / CFG_IN_W;
  localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS + 1) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORDS - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;
  localparam logic [1:0] S_ERROR  = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CFG_W-1:0]   shadow_q, shadow_d;
  logic [CFG_W-1:0]   active_q, active_d;
  logic               err_q, err_d;
  logic               acc;
  logic [CFG_W-1:0]   wmask;
  int                 sh;

  logic [NUM_OUT-1:0] mux;
  logic [NUM_OUT-1:0] mode_eff;
  logic [NUM_OUT-1:0] out_q;
  logic [NUM_OUT-1:0] out_w;

  assign cfg_ready  = (state_q == S_IDLE) || (state_q == S_LOAD);
  assign cfg_done   = (state_q == S_COMMIT);
  assign cfg_err    = err_q;
  assign cfg_active = active_q;
  assign acc        = cfg_valid && cfg_ready;

  always_comb begin
    for (int b = 0; b < CFG_W; b++) wmask[b] = (b < CFG_IN_W);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    active_d = active_q;
    err_d    = err_q;
    sh       = int'(cnt_q) * CFG_IN_W;
    if (acc) begin
      // bits that land past CFG_W fall off the top of the shift
      shadow_d = (shadow_q & ~(wmask << sh))
               | ((CFG_W'(cfg_data) & wmask) << sh);
      cnt_d    = cnt_q + 1'b1;
      err_d    = 1'b0;
    end
    unique case (state_q)
      S_IDLE: begin
        if (acc) begin
          if (cfg_last) state_d = (WORDS == 1) ? S_COMMIT : S_ERROR;
          else          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (acc) begin
          if (cfg_last && cnt_q == LAST_IDX) state_d = S_COMMIT;
          else if (cfg_last || cnt_q >= LAST_IDX) state_d = S_ERROR;
        end
      end
      S_COMMIT: begin
        active_d = shadow_q;
        cnt_d    = '0;
        state_d  = S_IDLE;
      end
      default: begin
        err_d    = 1'b1;
        shadow_d = '0;
        cnt_d    = '0;
        state_d  = S_IDLE;
      end
    endcase
    if (state_d == S_ERROR) err_d = 1'b1;
  end

  always_ff @(posedge UserCLK) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      active_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    mux = '0;
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < NUM_CH; i++) begin
        case (active_q[3*(d*NUM_CH+i) +: 2])
          2'd0:    mux[d*NUM_CH+i] = from_E[i];
          2'd1:    mux[d*NUM_CH+i] = from_W[i];
          2'd2:    mux[d*NUM_CH+i] = from_N[i];
          default: mux[d*NUM_CH+i] = from_S[i];
        endcase
      end
    end
  end

  generate
    if (OUT_REG_EN != 0) begin : g_reg
      always_comb begin
        for (int o = 0; o < NUM_OUT; o++) mode_eff[o] = active_q[3*o+2];
      end
      always_ff @(posedge UserCLK) begin
        if (rst) out_q <= '0;
        else     out_q <= mux;
      end
    end else begin : g_noreg
      assign mode_eff = '0;
      assign out_q    = '0;
    end
  endgenerate

  assign out_w = (mode_eff & out_q) | (~mode_eff & mux);
  assign to_W  = out_w[0        +: NUM_CH];
  assign to_N  = out_w[NUM_CH   +: NUM_CH];
  assign to_S  = out_w[2*NUM_CH +: NUM_CH];

endmodule
